// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls bytes from an upstream FIFO and serialises them as
// 8N1 (or 8E1 with PARITY_EN) frames, LSB first. Every output is a flop
// loaded from the next-state values, so tx is glitch-free and all the
// strobes line up with the state they describe.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_re,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, RD, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       sh, sh_n;
    logic             par, par_n;
    logic             tx_n, re_n, busy_n, done_n;
    logic             last;

    assign last = (cnt == CNT_LAST);

    // Next-state, counters and the values the output flops load next cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        bit_n   = bit_idx;
        sh_n    = sh;
        par_n   = par;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_en && !fifo_empty) state_n = RD;
            end
            RD: begin
                cnt_n   = '0;
                state_n = LOAD;
            end
            LOAD: begin
                // FIFO read data is valid here, one cycle after the strobe.
                sh_n    = fifo_data;
                par_n   = ^fifo_data;
                cnt_n   = '0;
                state_n = START;
            end
            START: begin
                if (last) begin
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        bit_n   = 3'd0;
                        state_n = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (last) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (last) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sh_n[bit_n];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
        re_n   = (state_n == RD);
        busy_n = (state_n != IDLE);
        done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
    end

    // State, datapath and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            sh        <= 8'h00;
            par       <= 1'b0;
            tx        <= 1'b1;
            fifo_re   <= 1'b0;
            busy      <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            sh        <= sh_n;
            par       <= par_n;
            tx        <= tx_n;
            fifo_re   <= re_n;
            busy      <= busy_n;
            byte_done <= done_n;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) at 4 clocks
// per bit, each fed by a behavioural FIFO. A frame-level model predicts every
// output cycle; a table of single-byte frames is also decoded off the line.
module tb_fifo_uart_tx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       tx_w[2], busy_w[2], re_w[2], bd_w[2], empty_w[2];
    logic [7:0] fdata[2];

    logic [7:0] mem[2][256];
    int         wp[2];
    int         rp[2];

    int nvec = 0;
    int nerr = 0;

    // frame model state
    bit         mon_on = 1'b0;
    bit         f_act[2];
    logic [7:0] f_byte[2];
    int         f_pos[2];
    int         re_total[2];
    logic       s_tx[2], s_busy[2], s_re[2], s_bd[2];

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0)) u0 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty_w[0]),
        .fifo_data(fdata[0]), .fifo_re(re_w[0]), .tx(tx_w[0]),
        .busy(busy_w[0]), .byte_done(bd_w[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) u1 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty_w[1]),
        .fifo_data(fdata[1]), .fifo_re(re_w[1]), .tx(tx_w[1]),
        .busy(busy_w[1]), .byte_done(bd_w[1]));

    assign empty_w[0] = (rp[0] == wp[0]);
    assign empty_w[1] = (rp[1] == wp[1]);

    // Upstream FIFO: registered read data one cycle after the strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (re_w[i] && rp[i] != wp[i]) begin
                fdata[i] <= mem[i][rp[i] & 255];
                rp[i]    <= rp[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        nvec++;
        if (act != exp_v) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic int frame_len(input int i);
        return 2 + N * (10 + i);
    endfunction

    // Expected {tx,busy,fifo_re,byte_done} at cycle p of a fetch (p=0 is RD).
    function automatic logic [3:0] frame_exp(input int i, input logic [7:0] b, input int p);
        int   bp;
        logic t;
        if (p < 2) return {1'b1, 1'b1, (p == 0), 1'b0};
        bp = (p - 2) / N;
        if (bp == 0)                t = 1'b0;
        else if (bp <= 8)           t = b[bp-1];
        else if (i == 1 && bp == 9) t = logic'($countones(b) % 2);
        else                        t = 1'b1;
        return {t, 1'b1, 1'b0, (p == frame_len(i) - 1)};
    endfunction

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wp[k] & 255] = b;
        wp[k]++;
    endtask

    // One cycle: sample and check at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [3:0] e;
        bit         was;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            s_tx[i] = tx_w[i]; s_busy[i] = busy_w[i]; s_re[i] = re_w[i]; s_bd[i] = bd_w[i];
            if (mon_on) begin
                e = f_act[i] ? frame_exp(i, f_byte[i], f_pos[i]) : 4'b1000;
                chk(i == 0 ? "cycle_u0" : "cycle_u1",
                    int'({s_tx[i], s_busy[i], s_re[i], s_bd[i]}), int'(e));
                if (s_re[i]) re_total[i]++;
                was = f_act[i];
                if (f_act[i]) begin
                    f_pos[i]++;
                    if (f_pos[i] == frame_len(i)) f_act[i] = 1'b0;
                end
                if (rst) f_act[i] = 1'b0;
                else if (!was && tx_en && !empty_w[i]) begin
                    f_act[i]  = 1'b1;
                    f_byte[i] = mem[i][rp[i] & 255];
                    f_pos[i]  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         exp_len;
        int         exp_par;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int         len, nre, frames, gap, bad, k;
        bit         started, done, counting;
        logic [7:0] dec;
        logic       pbit;

        tbl[0] = '{0, 8'hA5, 40, 0};
        tbl[1] = '{1, 8'hA5, 44, 0};
        tbl[2] = '{1, 8'h07, 44, 1};
        tbl[3] = '{0, 8'h00, 40, 0};
        tbl[4] = '{0, 8'hFF, 40, 0};
        tbl[5] = '{1, 8'hFF, 44, 0};
        tbl[6] = '{1, 8'h80, 44, 1};

        for (int i = 0; i < 2; i++) begin
            wp[i] = 0; f_act[i] = 1'b0; f_pos[i] = 0; re_total[i] = 0;
        end

        // reset state
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        tick();
        chk("reset_tx_u0", int'(s_tx[0]), 1);
        chk("reset_busy_u1", int'(s_busy[1]), 0);
        rst = 1'b0;
        tx_en = 1'b1;
        tick();

        // single-byte frames decoded from the line
        for (int v = 0; v < 7; v++) begin
            k = tbl[v].inst;
            push(k, tbl[v].data);
            started = 0; done = 0; len = 0; nre = 0; dec = 8'h00; pbit = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                tick();
                if (s_re[k]) nre++;
                if (!started && !s_tx[k]) started = 1;
                if (started) begin
                    if (len % N == N / 2) begin
                        if (len / N >= 1 && len / N <= 8) dec[len/N-1] = s_tx[k];
                        if (len / N == 9 && k == 1) pbit = s_tx[k];
                    end
                    len++;
                    if (s_bd[k]) done = 1;
                end
            end
            chk("vec_done", int'(done), 1);
            chk("vec_len", len, tbl[v].exp_len);
            chk("vec_data", int'(dec), int'(tbl[v].data));
            chk("vec_re_pulses", nre, 1);
            if (k == 1) chk("vec_parity", int'(pbit), tbl[v].exp_par);
        end

        // empty FIFO with tx_en high: line stays idle
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            for (int i = 0; i < 2; i++) if (s_re[i] || s_busy[i] || !s_tx[i]) bad++;
        end
        chk("idle_empty", bad, 0);

        // three queued bytes: ordered frames with a 3-cycle idle gap
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        frames = 0; nre = 0; gap = 0; counting = 0;
        for (int c = 0; c < 600 && frames < 3; c++) begin
            tick();
            if (s_re[0]) nre++;
            if (s_bd[0]) begin
                frames++; gap = 0; counting = 1;
            end else if (counting) begin
                if (!s_tx[0]) begin
                    chk("b2b_gap", gap, 3);
                    counting = 0;
                end else gap++;
            end
        end
        chk("b2b_frames", frames, 3);
        chk("b2b_re_pulses", nre, 3);
        tick();

        // tx_en dropped mid-frame: frame completes, then holds off
        push(0, 8'h3C); push(0, 8'h55);
        done = 0;
        for (int c = 0; c < 50 && !done; c++) begin tick(); if (!s_tx[0]) done = 1; end
        chk("txen_start_seen", int'(done), 1);
        repeat (12) tick();
        tx_en = 1'b0;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin tick(); if (s_bd[0]) done = 1; end
        chk("txen_frame_completes", int'(done), 1);
        nre = 0; bad = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (s_re[0]) nre++;
            if (s_busy[0]) bad++;
        end
        chk("txen_hold_re", nre, 0);
        chk("txen_hold_busy", bad, 0);
        chk("txen_fifo_level", wp[0] - rp[0], 1);
        tx_en = 1'b1;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin tick(); if (s_bd[0]) done = 1; end
        chk("txen_resume", int'(done), 1);
        tick();

        // reset during data bit 4 aborts; next fetch is the following byte
        push(0, 8'h9A); push(0, 8'h4B);
        done = 0;
        for (int c = 0; c < 50 && !done; c++) begin tick(); if (!s_tx[0]) done = 1; end
        chk("rst_start_seen", int'(done), 1);
        repeat (21) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_abort_tx", int'(s_tx[0]), 1);
        chk("rst_abort_busy", int'(s_busy[0]), 0);
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin tick(); if (s_bd[0]) done = 1; end
        chk("rst_refetch_done", int'(done), 1);
        chk("rst_fifo_level", wp[0] - rp[0], 0);

        // randomized traffic, tx_en toggling and occasional reset
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                k = int'($urandom_range(0, 1));
                if (wp[k] - rp[k] < 4) push(k, 8'($urandom));
            end
            tx_en = ($urandom_range(0, 7) != 0);
            rst   = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        tx_en = 1'b1;
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            tick();
            if (empty_w[0] && empty_w[1] && !f_act[0] && !f_act[1] && !s_busy[0] && !s_busy[1])
                done = 1;
        end
        chk("random_drained", int'(done), 1);
        chk("re_total_u0", re_total[0], wp[0]);
        chk("re_total_u1", re_total[1], wp[1]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
